// File: rtl/bus_pkg.sv
// Shared bus constants and packet type used by the terminal FIFOs and the bus driver.
package bus_pkg;
    localparam int unsigned PCKG_SZ    = 16;
    localparam int unsigned DRVS       = 4;
    localparam int unsigned DROP_CNT_W = 8;

    typedef logic [PCKG_SZ-1:0] pkt_t;
endpackage

// File: rtl/fifo_mem.sv
// Storage array for the terminal TX FIFO: synchronous write, asynchronous read.
module fifo_mem #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       we_i,
    input  logic [$clog2(DEPTH)-1:0]   waddr_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic [$clog2(DEPTH)-1:0]   raddr_i,
    output logic [WIDTH-1:0]           rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents are deliberately not reset; validity is tracked by the controller.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/terminal_tx_fifo.sv
// Per-terminal transmit FIFO feeding the bus driver: first-word fall-through head,
// overflow/underflow pulses and a saturating dropped-push counter.
module terminal_tx_fifo
    import bus_pkg::*;
#(
    parameter int unsigned pckg_sz = PCKG_SZ,
    parameter int unsigned depth   = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic [pckg_sz-1:0]          D_in,
    output logic                        full,
    output logic                        pndng,
    input  logic                        pop,
    output logic [pckg_sz-1:0]          D_pop,
    output logic [$clog2(depth):0]      count,
    output logic                        ovf,
    output logic                        udf,
    output logic [DROP_CNT_W-1:0]       drop_cnt
);
    localparam int unsigned AW = $clog2(depth);
    localparam int unsigned CW = AW + 1;

    if ((depth < 2) || (depth > 256) || ((depth & (depth - 1)) != 0)) begin : g_bad_depth
        $error("terminal_tx_fifo: depth must be a power of two in 2..256");
    end

    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic                  is_full, is_empty;
    logic                  do_push, do_pop;
    logic [pckg_sz-1:0]    head;

    assign is_full  = (count_q == CW'(depth));
    assign is_empty = (count_q == '0);

    // A push into a full FIFO still lands when the same edge frees the head slot.
    assign do_push = push && (!is_full || pop);
    assign do_pop  = pop && !is_empty;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;
        ovf_d      = push && !do_push;
        udf_d      = pop && is_empty;

        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
        if (ovf_d && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fifo_mem #(
        .WIDTH (pckg_sz),
        .DEPTH (depth)
    ) u_mem (
        .clk     (clk),
        .we_i    (do_push),
        .waddr_i (wr_ptr_q),
        .wdata_i (D_in),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    assign full     = is_full;
    assign pndng    = !is_empty;
    assign D_pop    = is_empty ? '0 : head;
    assign count    = count_q;
    assign ovf      = ovf_q;
    assign udf      = udf_q;
    assign drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_terminal_tx_fifo.sv
// Directed self-checking bench for terminal_tx_fifo (depth 8, 16-bit packets).
module tb_terminal_tx_fifo;
    logic        clk = 1'b0;
    logic        reset;
    logic        push;
    logic [15:0] D_in;
    logic        full;
    logic        pndng;
    logic        pop;
    logic [15:0] D_pop;
    logic [3:0]  count;
    logic        ovf;
    logic        udf;
    logic [7:0]  drop_cnt;

    int checks   = 0;
    int failures = 0;

    terminal_tx_fifo #(.pckg_sz(16), .depth(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .D_in     (D_in),
        .full     (full),
        .pndng    (pndng),
        .pop      (pop),
        .D_pop    (D_pop),
        .count    (count),
        .ovf      (ovf),
        .udf      (udf),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; outputs are stable 1 time unit after the edge.
    task automatic step(input logic p, input logic [15:0] d, input logic q);
        push = p;
        D_in = d;
        pop  = q;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        D_in = 16'h0;
    endtask

    task automatic do_reset();
        push  = 1'b0;
        pop   = 1'b0;
        D_in  = 16'h0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (count !== 4'd0)     begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (pndng !== 1'b0)     begin failures++; $display("FAIL reset_pndng got=%b exp=0", pndng); end
        checks++; if (full !== 1'b0)      begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (ovf !== 1'b0 || udf !== 1'b0) begin failures++; $display("FAIL reset_pulses ovf=%b udf=%b exp=0/0", ovf, udf); end
        checks++; if (drop_cnt !== 8'd0)  begin failures++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
        checks++; if (D_pop !== 16'h0)    begin failures++; $display("FAIL reset_dpop got=%h exp=0000", D_pop); end
    endtask

    task automatic test_basic();
        logic [15:0] exp_v [3];
        exp_v[0] = 16'h0101; exp_v[1] = 16'h0202; exp_v[2] = 16'h0303;
        do_reset();
        step(1'b1, 16'h0101, 1'b0);
        checks++; if (D_pop !== 16'h0101 || pndng !== 1'b1) begin failures++; $display("FAIL basic_first_visible dpop=%h pndng=%b exp=0101/1", D_pop, pndng); end
        step(1'b1, 16'h0202, 1'b0);
        step(1'b1, 16'h0303, 1'b0);
        checks++; if (count !== 4'd3) begin failures++; $display("FAIL basic_count3 got=%0d exp=3", count); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (D_pop !== exp_v[i]) begin failures++; $display("FAIL basic_dpop%0d got=%h exp=%h", i, D_pop, exp_v[i]); end
            step(1'b0, 16'h0, 1'b1);
            checks++; if (count !== 4'(2 - i)) begin failures++; $display("FAIL basic_count_after_pop%0d got=%0d exp=%0d", i, count, 2 - i); end
        end
        checks++; if (pndng !== 1'b0 || D_pop !== 16'h0) begin failures++; $display("FAIL basic_empty pndng=%b dpop=%h exp=0/0000", pndng, D_pop); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 16'h1000 + 16'(i), 1'b0);
        checks++; if (full !== 1'b1 || count !== 4'd8 || ovf !== 1'b0) begin failures++; $display("FAIL ovf_full full=%b count=%0d ovf=%b exp=1/8/0", full, count, ovf); end
        step(1'b1, 16'h9999, 1'b0);
        checks++; if (ovf !== 1'b1 || drop_cnt !== 8'd1 || count !== 4'd8) begin failures++; $display("FAIL ovf_drop ovf=%b drop=%0d count=%0d exp=1/1/8", ovf, drop_cnt, count); end
        step(1'b0, 16'h0, 1'b0);
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_one_cycle got=%b exp=0", ovf); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (D_pop !== 16'h1000 + 16'(i)) begin failures++; $display("FAIL ovf_order%0d got=%h exp=%h", i, D_pop, 16'h1000 + 16'(i)); end
            step(1'b0, 16'h0, 1'b1);
        end
        checks++; if (pndng !== 1'b0 || D_pop !== 16'h0) begin failures++; $display("FAIL ovf_ninth_absent pndng=%b dpop=%h exp=0/0000", pndng, D_pop); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 16'h2000 + 16'(i), 1'b0);
        step(1'b1, 16'hAAAA, 1'b1);
        checks++; if (count !== 4'd8 || ovf !== 1'b0 || full !== 1'b1) begin failures++; $display("FAIL fullpp_state count=%0d ovf=%b full=%b exp=8/0/1", count, ovf, full); end
        for (int i = 1; i < 8; i++) begin
            checks++; if (D_pop !== 16'h2000 + 16'(i)) begin failures++; $display("FAIL fullpp_order%0d got=%h exp=%h", i, D_pop, 16'h2000 + 16'(i)); end
            step(1'b0, 16'h0, 1'b1);
        end
        checks++; if (D_pop !== 16'hAAAA || count !== 4'd1) begin failures++; $display("FAIL fullpp_last dpop=%h count=%0d exp=aaaa/1", D_pop, count); end
    endtask

    task automatic test_underflow();
        do_reset();
        step(1'b0, 16'h0, 1'b1);
        checks++; if (udf !== 1'b1 || count !== 4'd0) begin failures++; $display("FAIL udf_alone udf=%b count=%0d exp=1/0", udf, count); end
        step(1'b0, 16'h0, 1'b0);
        checks++; if (udf !== 1'b0) begin failures++; $display("FAIL udf_one_cycle got=%b exp=0", udf); end
        step(1'b1, 16'h1234, 1'b1);
        checks++; if (udf !== 1'b1 || count !== 4'd1 || D_pop !== 16'h1234) begin failures++; $display("FAIL udf_with_push udf=%b count=%0d dpop=%h exp=1/1/1234", udf, count, D_pop); end
    endtask

    task automatic test_wrap();
        int q[$];
        logic p, r;
        do_reset();
        // Offset both pointers to 4 so the 20 pushes cross the wrap three times.
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 16'h4000 + 16'(k), 1'b0);
            checks++; if (D_pop !== 16'h4000 + 16'(k)) begin failures++; $display("FAIL wrap_warm%0d got=%h exp=%h", k, D_pop, 16'h4000 + 16'(k)); end
            step(1'b0, 16'h0, 1'b1);
        end
        for (int i = 0; i < 30; i++) begin
            p = (i < 20);
            r = (q.size() > 0) && ((i >= 20) || ((i % 3) != 0));
            if (r) begin
                checks++; if (D_pop !== 16'(q[0])) begin failures++; $display("FAIL wrap_order%0d got=%h exp=%h", i, D_pop, 16'(q[0])); end
                void'(q.pop_front());
            end
            if (p) q.push_back(32'h3000 + i);
            step(p, 16'h3000 + 16'(i), r);
            checks++; if (count !== 4'(q.size())) begin failures++; $display("FAIL wrap_count%0d got=%0d exp=%0d", i, count, q.size()); end
        end
        checks++; if (pndng !== 1'b0) begin failures++; $display("FAIL wrap_drained pndng=%b exp=0", pndng); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 16'h5000 + 16'(i), 1'b0);
        checks++; if (count !== 4'd5) begin failures++; $display("FAIL arst_pre_count got=%0d exp=5", count); end
        #2 reset = 1'b0;
        #1;
        checks++; if (pndng !== 1'b0 || count !== 4'd0 || D_pop !== 16'h0) begin failures++; $display("FAIL arst_immediate pndng=%b count=%0d dpop=%h exp=0/0/0000", pndng, count, D_pop); end
        @(posedge clk);
        #1 reset = 1'b1;
        step(1'b1, 16'h5555, 1'b0);
        checks++; if (count !== 4'd1 || D_pop !== 16'h5555) begin failures++; $display("FAIL arst_first_push count=%0d dpop=%h exp=1/5555", count, D_pop); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 16'h6000 + 16'(i), 1'b0);
        for (int i = 0; i < 254; i++) step(1'b1, 16'hDEAD, 1'b0);
        checks++; if (drop_cnt !== 8'd254) begin failures++; $display("FAIL sat_254 got=%0d exp=254", drop_cnt); end
        for (int i = 0; i < 46; i++) step(1'b1, 16'hDEAD, 1'b0);
        checks++; if (drop_cnt !== 8'd255 || ovf !== 1'b1 || count !== 4'd8) begin failures++; $display("FAIL sat_255 drop=%0d ovf=%b count=%0d exp=255/1/8", drop_cnt, ovf, count); end
        checks++; if (D_pop !== 16'h6000) begin failures++; $display("FAIL sat_head got=%h exp=6000", D_pop); end
    endtask

    initial begin
        reset = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        D_in  = 16'h0;
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_underflow();
        test_wrap();
        test_async_reset();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
